multi_port_register_file: RTL
=============================

// Module: multi_port_register_file
// PURPOSE
//   Next-generation register file with parametrised width, depth and read-port count.
//   - Registered reads with write-to-read bypass; one write port.
//   - Hardware clear sequencer that sweeps all entries to zero.
//   - Used by datapaths that need 2+ operand reads per cycle.
// PARAMETERS
//   N         8  bits per register
//   M         4  number of registers; power of 2, >= 2; AW = $clog2(M)
//   NUM_READ  2  number of independent read ports, >= 1
// PORTS
//   clk          in   1            single clock, rising edge
//   reset        in   1            synchronous, active-high
//   wr_en        in   1            write request
//   wr_addr      in   AW           write address
//   wr_data      in   N            write data
//   wr_ready     out  1            write accepted when wr_en & wr_ready
//   rd_en        in   NUM_READ     per-port read request
//   rd_addr      in   NUM_READ*AW  packed; port p = [p*AW +: AW]
//   rd_data      out  NUM_READ*N   packed; port p = [p*N +: N]
//   rd_valid     out  NUM_READ     per-port: rd_data valid this cycle
//   clear_req    in   1            pulse: start zeroing sweep
//   busy         out  1            clear sweep in progress
// BEHAVIOUR
//   Reset (sync, high): all regs=0, rd_data=0, rd_valid=0, busy=0, state=RF_IDLE, sweep ctr=0.
//   Write: accepted iff wr_en & wr_ready; reg[wr_addr] <= wr_data at that edge.
//   wr_ready = ~busy (registered state only, no input-to-output path).
//   Read latency 1 cycle: rd_en[p] at edge k -> rd_valid[p]=1 and rd_data[p] valid after edge k.
//   - rd_en[p]=0: rd_valid[p]=0 next cycle; rd_data[p] holds its last value.
//   Bypass: accepted write with wr_addr==rd_addr[p] in the same cycle -> rd_data[p]=wr_data (new data).
//   Multiple ports may read the same address in the same cycle; each receives identical data.
//   FSM: RF_IDLE --clear_req--> RF_CLEAR; RF_CLEAR --ctr==M-1--> RF_IDLE.
//   RF_CLEAR:
//   - reg[ctr] <= 0 and ctr increments each cycle, so the sweep takes exactly M cycles.
//   - busy=1 from the cycle after clear_req until the cycle after the last entry is cleared.
//   - clear_req while busy is ignored; no queuing.
//   - Reads during sweep are allowed and return current contents (0 if already swept).
//   - wr_ready=0 during sweep; no writes occur.
//   clear_req & accepted wr_en in the same IDLE cycle: write happens, then the sweep zeroes it.
//   Reset mid-sweep: abort to RF_IDLE, all entries 0, ctr=0.
//   Addresses are full-range (M is a power of 2); no out-of-range case exists.
// CONFIGURATION
//   Macro RF_ZERO_REG_EN:
//   - Defined: reg[0] is hardwired 0; writes to addr 0 are accepted (wr_ready rules unchanged) but discarded.
//     Reads of addr 0 return 0, and bypass never forwards to addr 0.
//   - Undefined: reg[0] behaves like every other entry.
// STRUCTURE
//   Package regfile_pkg:
//   - typedef enum {RF_IDLE, RF_CLEAR} rf_state_t.
//   - Function rf_addr_w(M) returning $clog2(M).
//   Sub-module rf_read_port:
//   - One registered read port: mux, bypass compare, rd_data/rd_valid flops.
//   - Instantiated NUM_READ times via generate.
//   Storage array, write decode and clear FSM/counter live in the top module.
// TESTING (N=8, M=4, NUM_READ=2 unless stated)
//   1 Write 0x05->r0, 0x0A->r1; then rd0=r0, rd1=r1 same cycle -> next cycle rd_data 0x05/0x0A, rd_valid=2'b11.
//   2 Bypass: r2=0x11; same cycle wr r2=0xF0 and rd0=r2 -> rd_data0=0xF0 next cycle.
//   3 Clear: fill r0..r3 = 1,2,3,4; pulse clear_req.
//     -> busy=1 for 4 cycles, wr_ready=0 throughout, a write attempt is dropped.
//     -> afterwards all reads return 0.
//   4 Mid-sweep read: read r3 while ctr=1 -> old value 0x04; read r0 -> 0x00.
//   5 Reset asserted during sweep -> next cycle busy=0, rd_valid=0, all entries read 0.
//   6 RF_ZERO_REG_EN defined: write 0xFF->r0 then read r0 -> 0x00; bypass on r0 -> 0x00.
//     Same test with macro undefined -> 0xFF.

Source files
------------

// File: rtl/multi_port_register_file_pkg.sv
// regfile_pkg: shared types and helpers for multi_port_register_file.
// Provides the clear-sequencer state enum and the address-width helper.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE,
    RF_CLEAR
  } rf_state_t;

  function automatic int rf_addr_w(int m);
    return $clog2(m);
  endfunction

endpackage

// File: rtl/multi_port_register_file_if.sv
// multi_port_register_file_if: write port, packed read ports, clear handshake.
// master drives wr_*/rd_en/rd_addr/clear_req; slave drives wr_ready/rd_*/busy.
interface multi_port_register_file_if
  import regfile_pkg::*;
#(
  parameter int N        = 8,
  parameter int M        = 4,
  parameter int NUM_READ = 2
);
  localparam int AW = rf_addr_w(M);

  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [N-1:0]           wr_data;
  logic                   wr_ready;
  logic [NUM_READ-1:0]    rd_en;
  logic [NUM_READ*AW-1:0] rd_addr;
  logic [NUM_READ*N-1:0]  rd_data;
  logic [NUM_READ-1:0]    rd_valid;
  logic                   clear_req;
  logic                   busy;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en, rd_addr, clear_req,
    input  wr_ready, rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en, rd_addr, clear_req,
    output wr_ready, rd_data, rd_valid, busy
  );

endinterface

// File: rtl/multi_port_register_file_rf_read_port.sv
// rf_read_port: one registered read port with write-to-read bypass.
// Ports: clk_i, reset_i, rd_en_i/rd_addr_i, wr_*_i bypass, mem_i, rd_data_o/rd_valid_o. Macro: RF_ZERO_REG_EN.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int N  = 8,
  parameter int M  = 4,
  parameter int AW = rf_addr_w(M)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          wr_fire_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [N-1:0]  wr_data_i,
  input  logic [N-1:0]  mem_i [M],
  output logic [N-1:0]  rd_data_o,
  output logic          rd_valid_o
);

  logic [N-1:0] data_d;
  logic [N-1:0] data_q;
  logic         valid_q;

  always_comb begin
    data_d = mem_i[rd_addr_i];
    if (wr_fire_i && (wr_addr_i == rd_addr_i))
      data_d = wr_data_i;
`ifdef RF_ZERO_REG_EN
    // entry 0 is hardwired; this also blocks bypass to it
    if (rd_addr_i == '0)
      data_d = '0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_en_i;
      if (rd_en_i)
        data_q <= data_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;

endmodule

// File: rtl/multi_port_register_file.sv
// multi_port_register_file: storage, write decode, clear sweep FSM, NUM_READ read ports.
// Ports: clk, reset (sync, high), bus (slave modport). Macro: RF_ZERO_REG_EN.
module multi_port_register_file
  import regfile_pkg::*;
#(
  parameter int N        = 8,
  parameter int M        = 4,
  parameter int NUM_READ = 2
) (
  input logic                       clk,
  input logic                       reset,
  multi_port_register_file_if.slave bus
);

  localparam int AW = rf_addr_w(M);

  logic [N-1:0]  mem_q [M];
  rf_state_t     state_q;
  logic [AW-1:0] ctr_q;
  logic          busy;
  logic          wr_fire;
  logic          wr_keep;

  assign busy         = (state_q == RF_CLEAR);
  assign bus.busy     = busy;
  assign bus.wr_ready = ~busy;
  assign wr_fire      = bus.wr_en & ~busy;

`ifdef RF_ZERO_REG_EN
  assign wr_keep = wr_fire & (bus.wr_addr != '0);
`else
  assign wr_keep = wr_fire;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < M; i++)
        mem_q[i] <= '0;
      state_q <= RF_IDLE;
      ctr_q   <= '0;
    end else begin
      unique case (state_q)
        RF_IDLE: begin
          if (wr_keep)
            mem_q[bus.wr_addr] <= bus.wr_data;
          // a write in the same cycle lands first, the sweep zeroes it later
          if (bus.clear_req) begin
            state_q <= RF_CLEAR;
            ctr_q   <= '0;
          end
        end
        RF_CLEAR: begin
          mem_q[ctr_q] <= '0;
          ctr_q        <= ctr_q + AW'(1);
          if (ctr_q == AW'(M - 1))
            state_q <= RF_IDLE;
        end
        default: state_q <= RF_IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [N-1:0] data;
    logic         valid;

    rf_read_port #(
      .N (N),
      .M (M),
      .AW(AW)
    ) u_rd (
      .clk_i     (clk),
      .reset_i   (reset),
      .rd_en_i   (bus.rd_en[p]),
      .rd_addr_i (bus.rd_addr[p*AW +: AW]),
      .wr_fire_i (wr_fire),
      .wr_addr_i (bus.wr_addr),
      .wr_data_i (bus.wr_data),
      .mem_i     (mem_q),
      .rd_data_o (data),
      .rd_valid_o(valid)
    );

    assign bus.rd_data[p*N +: N] = data;
    assign bus.rd_valid[p]       = valid;
  end

endmodule
